// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register: one-cycle copy of decoded control, operands and immediates,
// with flush (bubble insert) over freeze (hold) priority and a saturating bubble counter.
module id_ex_stage_reg #(
    parameter int WORD_LEN = 32,
    parameter int CNT_LEN  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                flush,
    input  logic                valid_in,
    input  logic [WORD_LEN-1:0] pc_in,
    input  logic                wb_en_in,
    input  logic                mem_r_en_in,
    input  logic                mem_w_en_in,
    input  logic [3:0]          exe_cmd_in,
    input  logic                b_in,
    input  logic                s_in,
    input  logic                imm_in,
    input  logic [11:0]         shift_operand_in,
    input  logic [23:0]         imm24_in,
    input  logic [3:0]          dest_in,
    input  logic [3:0]          src1_in,
    input  logic [3:0]          src2_in,
    input  logic [WORD_LEN-1:0] val_rn_in,
    input  logic [WORD_LEN-1:0] val_rm_in,
    input  logic                carry_in,
    output logic                valid_out,
    output logic [WORD_LEN-1:0] pc_out,
    output logic                wb_en_out,
    output logic                mem_r_en_out,
    output logic                mem_w_en_out,
    output logic [3:0]          exe_cmd_out,
    output logic                b_out,
    output logic                s_out,
    output logic                imm_out,
    output logic [11:0]         shift_operand_out,
    output logic [23:0]         imm24_out,
    output logic [3:0]          dest_out,
    output logic [3:0]          src1_out,
    output logic [3:0]          src2_out,
    output logic [WORD_LEN-1:0] val_rn_out,
    output logic [WORD_LEN-1:0] val_rm_out,
    output logic                carry_out,
    output logic [CNT_LEN-1:0]  bubble_cnt
);

    typedef struct packed {
        logic                valid;
        logic [WORD_LEN-1:0] pc;
        logic                wb_en;
        logic                mem_r_en;
        logic                mem_w_en;
        logic [3:0]          exe_cmd;
        logic                b;
        logic                s;
        logic                imm;
        logic [11:0]         shift_operand;
        logic [23:0]         imm24;
        logic [3:0]          dest;
        logic [3:0]          src1;
        logic [3:0]          src2;
        logic [WORD_LEN-1:0] val_rn;
        logic [WORD_LEN-1:0] val_rm;
        logic                carry;
    } stage_t;

    localparam logic [CNT_LEN-1:0] CNT_MAX = '1;

    stage_t             w_load;
    stage_t             r_stage;
    logic [CNT_LEN-1:0] r_bubble_cnt;

    always_comb begin
        w_load.valid         = valid_in;
        w_load.pc            = pc_in;
        w_load.wb_en         = wb_en_in;
        w_load.mem_r_en      = mem_r_en_in;
        w_load.mem_w_en      = mem_w_en_in;
        w_load.exe_cmd       = exe_cmd_in;
        w_load.b             = b_in;
        w_load.s             = s_in;
        w_load.imm           = imm_in;
        w_load.shift_operand = shift_operand_in;
        w_load.imm24         = imm24_in;
        w_load.dest          = dest_in;
        w_load.src1          = src1_in;
        w_load.src2          = src2_in;
        w_load.val_rn        = val_rn_in;
        w_load.val_rm        = val_rm_in;
        w_load.carry         = carry_in;
    end

    // The counter looks at the currently presented valid, so a held bubble keeps counting under freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage      <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (!r_stage.valid && (r_bubble_cnt != CNT_MAX))
                r_bubble_cnt <= r_bubble_cnt + CNT_LEN'(1);
            if (flush)
                r_stage <= '0;
            else if (!freeze)
                r_stage <= w_load;
        end
    end

    assign valid_out         = r_stage.valid;
    assign pc_out            = r_stage.pc;
    assign wb_en_out         = r_stage.wb_en;
    assign mem_r_en_out      = r_stage.mem_r_en;
    assign mem_w_en_out      = r_stage.mem_w_en;
    assign exe_cmd_out       = r_stage.exe_cmd;
    assign b_out             = r_stage.b;
    assign s_out             = r_stage.s;
    assign imm_out           = r_stage.imm;
    assign shift_operand_out = r_stage.shift_operand;
    assign imm24_out         = r_stage.imm24;
    assign dest_out          = r_stage.dest;
    assign src1_out          = r_stage.src1;
    assign src2_out          = r_stage.src2;
    assign val_rn_out        = r_stage.val_rn;
    assign val_rm_out        = r_stage.val_rm;
    assign carry_out         = r_stage.carry;
    assign bubble_cnt        = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: whole-word model compared every negedge, plus literal spot checks.
module tb_id_ex_stage_reg;

    localparam int VW = 156;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in;
    logic        b_in, s_in, imm_in, carry_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic [3:0]  exe_cmd_in, dest_in, src1_in, src2_in;
    logic [11:0] shift_operand_in;
    logic [23:0] imm24_in;

    logic        valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, carry_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out;
    logic [11:0] shift_operand_out;
    logic [23:0] imm24_out;
    logic [15:0] bubble_cnt;

    logic        s_valid_out, s_wb_en_out, s_mem_r_en_out, s_mem_w_en_out, s_b_out, s_s_out, s_imm_out, s_carry_out;
    logic [31:0] s_pc_out, s_val_rn_out, s_val_rm_out;
    logic [3:0]  s_exe_cmd_out, s_dest_out, s_src1_out, s_src2_out;
    logic [11:0] s_shift_operand_out;
    logic [23:0] s_imm24_out;
    logic [3:0]  s_bubble_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.WORD_LEN(32), .CNT_LEN(16)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in), .pc_in(pc_in),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .exe_cmd_in(exe_cmd_in), .b_in(b_in), .s_in(s_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in), .imm24_in(imm24_in), .dest_in(dest_in),
        .src1_in(src1_in), .src2_in(src2_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .carry_in(carry_in),
        .valid_out(valid_out), .pc_out(pc_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .exe_cmd_out(exe_cmd_out), .b_out(b_out), .s_out(s_out),
        .imm_out(imm_out), .shift_operand_out(shift_operand_out), .imm24_out(imm24_out),
        .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .val_rn_out(val_rn_out),
        .val_rm_out(val_rm_out), .carry_out(carry_out), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage_reg #(.WORD_LEN(32), .CNT_LEN(4)) dut_small (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in), .pc_in(pc_in),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .exe_cmd_in(exe_cmd_in), .b_in(b_in), .s_in(s_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in), .imm24_in(imm24_in), .dest_in(dest_in),
        .src1_in(src1_in), .src2_in(src2_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .carry_in(carry_in),
        .valid_out(s_valid_out), .pc_out(s_pc_out), .wb_en_out(s_wb_en_out),
        .mem_r_en_out(s_mem_r_en_out), .mem_w_en_out(s_mem_w_en_out), .exe_cmd_out(s_exe_cmd_out),
        .b_out(s_b_out), .s_out(s_s_out), .imm_out(s_imm_out),
        .shift_operand_out(s_shift_operand_out), .imm24_out(s_imm24_out), .dest_out(s_dest_out),
        .src1_out(s_src1_out), .src2_out(s_src2_out), .val_rn_out(s_val_rn_out),
        .val_rm_out(s_val_rm_out), .carry_out(s_carry_out), .bubble_cnt(s_bubble_cnt)
    );

    // Whole instruction as one word; the model only ever moves this word around.
    wire [VW-1:0] in_vec = {valid_in, pc_in, wb_en_in, mem_r_en_in, mem_w_en_in, exe_cmd_in,
                            b_in, s_in, imm_in, shift_operand_in, imm24_in, dest_in, src1_in,
                            src2_in, val_rn_in, val_rm_in, carry_in};
    wire [VW-1:0] out_vec = {valid_out, pc_out, wb_en_out, mem_r_en_out, mem_w_en_out, exe_cmd_out,
                             b_out, s_out, imm_out, shift_operand_out, imm24_out, dest_out, src1_out,
                             src2_out, val_rn_out, val_rm_out, carry_out};
    wire [VW-1:0] s_out_vec = {s_valid_out, s_pc_out, s_wb_en_out, s_mem_r_en_out, s_mem_w_en_out,
                               s_exe_cmd_out, s_b_out, s_s_out, s_imm_out, s_shift_operand_out,
                               s_imm24_out, s_dest_out, s_src1_out, s_src2_out, s_val_rn_out,
                               s_val_rm_out, s_carry_out};

    logic [VW-1:0] m_word;
    int            m_bubbles = 0;
    bit            m_known   = 0;

    // Model: count presented bubbles as a plain integer, clamp for each counter width when comparing.
    always @(posedge clk) begin
        if (rst) begin
            m_word    = '0;
            m_bubbles = 0;
            m_known   = 1;
        end else if (m_known) begin
            if (m_word[VW-1] == 1'b0) m_bubbles = m_bubbles + 1;
            if (flush)        m_word = '0;
            else if (!freeze) m_word = in_vec;
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            n_cmp = n_cmp + 3;
            if (out_vec !== m_word || s_out_vec !== m_word) begin
                n_fail = n_fail + 1;
                $display("FAIL model_fields t=%0t got %h small %h want %h", $time, out_vec, s_out_vec, m_word);
            end
            if (int'(bubble_cnt) != ((m_bubbles > 65535) ? 65535 : m_bubbles)) begin
                n_fail = n_fail + 1;
                $display("FAIL model_bubble16 t=%0t got %0d want %0d", $time, bubble_cnt, m_bubbles);
            end
            if (int'(s_bubble_cnt) != ((m_bubbles > 15) ? 15 : m_bubbles)) begin
                n_fail = n_fail + 1;
                $display("FAIL model_bubble4 t=%0t got %0d want %0d", $time, s_bubble_cnt, m_bubbles);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        valid_in = 0; pc_in = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; exe_cmd_in = 0;
        b_in = 0; s_in = 0; imm_in = 0; shift_operand_in = 0; imm24_in = 0; dest_in = 0;
        src1_in = 0; src2_in = 0; val_rn_in = 0; val_rm_in = 0; carry_in = 0;
    endtask

    task automatic fill_in(input logic [31:0] seed);
        valid_in = 1; pc_in = seed; wb_en_in = seed[0]; mem_r_en_in = seed[1]; mem_w_en_in = seed[2];
        exe_cmd_in = seed[7:4]; b_in = seed[8]; s_in = seed[9]; imm_in = seed[10];
        shift_operand_in = seed[23:12]; imm24_in = {seed[15:0], seed[31:24]}; dest_in = seed[11:8];
        src1_in = seed[19:16]; src2_in = seed[27:24]; val_rn_in = ~seed; val_rm_in = {seed[15:0], seed[31:16]};
        carry_in = seed[31];
    endtask

    logic [31:0] patterns [6] = '{32'hFFFF_FFFF, 32'h8000_0001, 32'h1234_5678,
                                   32'hA5A5_5A5A, 32'h0F0F_F0F0, 32'hDEAD_BEEF};

    initial begin
        rst = 1; freeze = 0; flush = 0;
        fill_in(32'hCAFE_F00D);
        tick(); tick();
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_pc", 64'(pc_out), 64'd0);
        chk("rst_wb_en", 64'(wb_en_out), 64'd0);
        chk("rst_bubble", 64'(bubble_cnt), 64'd0);

        rst = 0; clr_in();
        pc_in = 32'h14; val_rn_in = 32'hAAAA5555; dest_in = 4'd3; wb_en_in = 1; valid_in = 1;
        tick();
        chk("load_pc", 64'(pc_out), 64'h14);
        chk("load_val_rn", 64'(val_rn_out), 64'hAAAA5555);
        chk("load_dest", 64'(dest_out), 64'd3);
        chk("load_wb_en", 64'(wb_en_out), 64'd1);
        chk("load_valid", 64'(valid_out), 64'd1);
        chk("load_bubble", 64'(bubble_cnt), 64'd1);
        #3;
        clr_in();
        pc_in = 32'h18; val_rn_in = 32'h11112222; dest_in = 4'd5; mem_w_en_in = 1; valid_in = 1;
        #1;
        chk("midcycle_pc", 64'(pc_out), 64'h14);
        chk("midcycle_val_rn", 64'(val_rn_out), 64'hAAAA5555);
        tick();
        chk("preload_pc", 64'(pc_out), 64'h18);

        freeze = 1;
        for (int i = 0; i < 3; i++) begin
            fill_in(32'h5A5A_0000 ^ 32'(i * 32'h1111_3333));
            tick();
            chk("freeze_pc", 64'(pc_out), 64'h18);
            chk("freeze_val_rn", 64'(val_rn_out), 64'h11112222);
            chk("freeze_dest", 64'(dest_out), 64'd5);
            chk("freeze_mem_w", 64'(mem_w_en_out), 64'd1);
        end

        flush = 1;
        tick();
        chk("flush_valid", 64'(valid_out), 64'd0);
        chk("flush_wb_en", 64'(wb_en_out), 64'd0);
        chk("flush_mem_w", 64'(mem_w_en_out), 64'd0);
        chk("flush_val_rn", 64'(val_rn_out), 64'd0);
        chk("flush_bubble", 64'(bubble_cnt), 64'd1);

        flush = 0; freeze = 0; clr_in();
        repeat (20) tick();
        chk("sat_small", 64'(s_bubble_cnt), 64'd15);
        chk("count_main", 64'(bubble_cnt), 64'd21);

        foreach (patterns[k]) begin
            fill_in(patterns[k]);
            freeze = (k == 2);
            flush  = (k == 4);
            tick();
        end
        freeze = 0; flush = 0;

        clr_in(); valid_in = 1; mem_w_en_in = 1; pc_in = 32'h30;
        tick();
        chk("store_loaded", 64'(mem_w_en_out), 64'd1);
        rst = 1;
        tick();
        chk("rst_store_mem_w", 64'(mem_w_en_out), 64'd0);
        chk("rst_store_valid", 64'(valid_out), 64'd0);
        chk("rst_store_bubble", 64'(bubble_cnt), 64'd0);
        rst = 0; clr_in(); valid_in = 1; pc_in = 32'h40;
        tick();
        chk("post_rst_valid", 64'(valid_out), 64'd1);
        chk("post_rst_pc", 64'(pc_out), 64'h40);
        chk("post_rst_bubble", 64'(bubble_cnt), 64'd1);

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
